// File: rtl/hpdcache_downsize_arbiter.sv
// rtl/hpdcache_downsize_arbiter.sv - N-requester wide-word arbiter with word storage and narrow beat output
// Optional feature macro: HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN (fixed-priority grant, lowest index wins)
module hpdcache_downsize_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned WR_WIDTH = 256,
  parameter int unsigned RD_WIDTH = 64,
  parameter int unsigned DEPTH    = 2,
  localparam int unsigned ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*WR_WIDTH-1:0] req_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RD_WIDTH-1:0]       rsp_data_o,
  output logic [ID_WIDTH-1:0]       rsp_id_o,
  output logic                      rsp_last_o
);

  localparam int unsigned RD_WORDS = WR_WIDTH / RD_WIDTH;
  localparam int unsigned BEAT_W   = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  // Requester words viewed as an array; each stored word viewed as an array of beats
  logic [N_REQ-1:0][WR_WIDTH-1:0]    req_words;
  logic [RD_WORDS-1:0][RD_WIDTH-1:0] mem_data [DEPTH];
  logic [ID_WIDTH-1:0]               mem_id   [DEPTH];

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [BEAT_W-1:0]   beat;
  logic                full;
  logic                push;
  logic                pop;
  logic                pop_last;
  logic                gnt_found;
  logic [ID_WIDTH-1:0] gnt_idx;

  assign req_words = req_data_i;

  // Storage full blocks every requester, even if the head word retires this cycle
  assign full = (count == CNT_W'(DEPTH));

`ifdef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_WIDTH'(k);
      end
    end
  end
`else
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH:0]   cand;

  // Round-robin: first valid requester at or after rr_ptr, wrapping past N_REQ-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
      if (cand >= (ID_WIDTH + 1)'(N_REQ)) begin
        cand = cand - (ID_WIDTH + 1)'(N_REQ);
      end
      if (!gnt_found && req_valid_i[cand[ID_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Priority moves just past the requester that was last accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // One-hot accept towards the winner; silenced while reset is held
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && !full && gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign push     = |req_ready_o;
  assign pop      = rsp_valid_o & rsp_ready_i;
  assign pop_last = pop & rsp_last_o;

  assign rsp_valid_o = (count != '0);
  assign rsp_data_o  = mem_data[rd_ptr][beat];
  assign rsp_id_o    = mem_id[rd_ptr];
  assign rsp_last_o  = rsp_valid_o & (beat == BEAT_W'(RD_WORDS - 1));

  // Word storage: the accepted requester's word and id land at wr_ptr
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= req_words[gnt_idx];
      mem_id[wr_ptr]   <= gnt_idx;
    end
  end

  // Write pointer advances per accepted word, wrapping at DEPTH-1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances once the last beat of the head word is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
    end else if (pop_last) begin
      rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy: a push and a word retirement in the same cycle cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else begin
      case ({push, pop_last})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Beat index within the head word, LSB beat first, rewinds after the last beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat <= '0;
    end else if (pop) begin
      beat <= pop_last ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_hpdcache_downsize_arbiter.sv
// tb/tb_hpdcache_downsize_arbiter.sv - directed and random checks of the downsize arbiter against a queue model
`timescale 1ns/1ps
module tb_hpdcache_downsize_arbiter;

  localparam int N_REQ    = 2;
  localparam int WR_WIDTH = 256;
  localparam int RD_WIDTH = 64;
  localparam int DEPTH    = 2;
  localparam int RD_WORDS = WR_WIDTH / RD_WIDTH;
  localparam int ID_WIDTH = 1;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [N_REQ-1:0]          req_valid_i;
  logic [N_REQ-1:0]          req_ready_o;
  logic [N_REQ*WR_WIDTH-1:0] req_data_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [RD_WIDTH-1:0]       rsp_data_o;
  logic [ID_WIDTH-1:0]       rsp_id_o;
  logic                      rsp_last_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of whole words, beat index of head word, round-robin pointer
  logic [WR_WIDTH-1:0] q_data[$];
  int                  q_id[$];
  int                  m_beat = 0;
  int                  m_rr   = 0;

  // Values seen in the most recent step, for directed constant checks
  logic [N_REQ-1:0]    obs_rdy;
  logic [RD_WIDTH-1:0] obs_data;
  logic                obs_last;
  logic                obs_valid;
  logic [ID_WIDTH-1:0] obs_id;

  hpdcache_downsize_arbiter #(
    .N_REQ(N_REQ), .WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_id_o(rsp_id_o), .rsp_last_o(rsp_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N_REQ-1:0] v);
    if (q_data.size() >= DEPTH) return -1;
`ifdef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N_REQ; k++) if (v[(m_rr + k) % N_REQ]) return (m_rr + k) % N_REQ;
`endif
    return -1;
  endfunction

  function automatic logic [WR_WIDTH-1:0] rand_word();
    logic [WR_WIDTH-1:0] w;
    for (int i = 0; i < WR_WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock cycle: drive, check all outputs against the model, then advance the model
  task automatic step(input logic [N_REQ-1:0] v, input logic [WR_WIDTH-1:0] d0,
                      input logic [WR_WIDTH-1:0] d1, input logic rr);
    int                  g;
    logic [N_REQ-1:0]    exp_rdy;
    logic [WR_WIDTH-1:0] w;
    @(negedge clk_i);
    req_valid_i = v;
    req_data_i  = {d1, d0};
    rsp_ready_i = rr;
    #1;
    obs_rdy = req_ready_o; obs_data = rsp_data_o; obs_last = rsp_last_o;
    obs_valid = rsp_valid_o; obs_id = rsp_id_o;
    g = model_grant(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(q_data.size() != 0));
    if (q_data.size() != 0) begin
      w = q_data[0];
      chk("rsp_data", rsp_data_o, w[m_beat*RD_WIDTH +: RD_WIDTH]);
      chk("rsp_id", 64'(rsp_id_o), 64'(q_id[0]));
      chk("rsp_last", 64'(rsp_last_o), 64'(m_beat == RD_WORDS - 1));
    end else begin
      chk("rsp_last_idle", 64'(rsp_last_o), 64'd0);
    end
    @(posedge clk_i);
    if (q_data.size() != 0 && rr) begin
      if (m_beat == RD_WORDS - 1) begin
        void'(q_data.pop_front());
        void'(q_id.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (g >= 0) begin
      q_data.push_back(g == 0 ? d0 : d1);
      q_id.push_back(g);
      m_rr = (g + 1) % N_REQ;
    end
  endtask

  // Asynchronous reset: outputs must drop immediately, model is emptied
  task automatic do_reset();
    @(negedge clk_i);
    req_valid_i = '1;
    rst_ni = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id_o), 64'd0);
    q_data.delete();
    q_id.delete();
    m_beat = 0;
    m_rr   = 0;
    repeat (2) @(negedge clk_i);
    req_valid_i = '0;
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_data.size() != 0; i++) step('0, '0, '0, 1'b1);
    chk("drain_empty", 64'(q_data.size()), 64'd0);
  endtask

  logic [WR_WIDTH-1:0] word_a;

  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b0;

    do_reset();

    // Single word from requester 0, beats 1..4, last only on the fourth
    word_a = {64'h4, 64'h3, 64'h2, 64'h1};
    step(2'b01, word_a, '0, 1'b1);
    chk("r32_ready", 64'(obs_rdy), 64'h1);
    for (int b = 1; b <= RD_WORDS; b++) begin
      step(2'b00, '0, '0, 1'b1);
      chk("r32_beat", obs_data, 64'(b));
      chk("r32_id", 64'(obs_id), 64'd0);
      chk("r32_last", 64'(obs_last), 64'(b == RD_WORDS));
    end

    // Both requesters continuously valid with a free-running consumer
    for (int i = 0; i < 24; i++) step(2'b11, rand_word(), rand_word(), 1'b1);
    drain();

    // Stalled consumer: two pushes fill storage, then accepts stop
    for (int i = 0; i < 4; i++) begin
      step(2'b11, rand_word(), rand_word(), 1'b0);
      if (i >= 2) chk("r34_full_ready", 64'(obs_rdy), 64'd0);
    end
    for (int i = 0; i < 8; i++) step(2'b11, rand_word(), rand_word(), 1'b1);
    drain();

    // Reset after two beats of a word have been taken
    step(2'b10, '0, rand_word(), 1'b1);
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b1);
    do_reset();
    step(2'b11, rand_word(), rand_word(), 1'b1);
    chk("r36_ready_after_rst", 64'(obs_rdy), 64'h1);
    chk("r36_valid_after_rst", 64'(obs_valid), 64'd0);
    step(2'b00, '0, '0, 1'b1);
    chk("r36_new_word_valid", 64'(obs_valid), 64'd1);
    drain();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(N_REQ'($urandom_range(3)), rand_word(), rand_word(), $urandom_range(3) != 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_downsize_arbiter.md
HPDCACHE_DOWNSIZE_ARBITER -- requirements
Module: hpdcache_downsize_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of wide-word requesters (>=2).
REQ-002 SHALL have parameter WR_WIDTH, default 256: requester word width in bits.
REQ-003 SHALL have parameter RD_WIDTH, default 64: output beat width; WR_WIDTH SHALL be an integer multiple of it; RD_WORDS = WR_WIDTH/RD_WIDTH >= 2.
REQ-004 SHALL have parameter DEPTH, default 2: number of wide-word storage entries (>=2).
REQ-005 SHALL define ID_WIDTH = max(1, clog2(N_REQ)).
REQ-006 clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 req_valid_i  input  N_REQ  per-requester write request.
REQ-009 req_ready_o  output  N_REQ  per-requester accept (one-hot or zero).
REQ-010 req_data_i  input  N_REQ*WR_WIDTH  requester i word at bits [i*WR_WIDTH +: WR_WIDTH].
REQ-011 rsp_valid_o  output  1  beat available.
REQ-012 rsp_ready_i  input  1  consumer accepts beat.
REQ-013 rsp_data_o  output  RD_WIDTH  current beat.
REQ-014 rsp_id_o  output  ID_WIDTH  index of requester owning current beat.
REQ-015 rsp_last_o  output  1  current beat is last of its wide word.

Function
REQ-016 Push occurs when some req_valid_i[i] & req_ready_o[i]; pop-beat occurs when rsp_valid_o & rsp_ready_i.
REQ-017 req_ready_o SHALL be all-zero when storage holds DEPTH entries, regardless of a same-cycle pop (no push-through-full).
REQ-018 When not full, exactly one valid requester SHALL be granted per cycle: round-robin, search starting at rr_ptr, ascending, wrapping at N_REQ-1 -> 0.
REQ-019 On push from requester g, rr_ptr SHALL become (g+1) mod N_REQ next cycle; with no push rr_ptr holds.
REQ-020 On push, entry at wr_ptr SHALL store req_data_i slice g and id g; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-021 rsp_valid_o SHALL equal (entry count != 0); a pushed word SHALL be visible on rsp_valid_o the cycle after push (1-cycle latency).
REQ-022 rsp_data_o SHALL be bits [beat*RD_WIDTH +: RD_WIDTH] of entry at rd_ptr (LSB beat first); rsp_id_o the entry's id.
REQ-023 beat counter (clog2(RD_WORDS) bits) SHALL increment on each pop-beat; rsp_last_o = rsp_valid_o & (beat == RD_WORDS-1).
REQ-024 Pop-beat with rsp_last_o SHALL clear beat to 0, advance rd_ptr (wrapping DEPTH-1 -> 0) and release the entry.
REQ-025 Simultaneous push and last-beat pop SHALL leave entry count unchanged; push alone +1; last pop alone -1.
REQ-026 rsp_data_o/rsp_id_o SHALL hold stable while rsp_valid_o & ~rsp_ready_i.
REQ-027 Requester dropping req_valid_i without acceptance SHALL leave state unchanged.

Reset
REQ-028 On rst_ni low, asynchronously: wr_ptr, rd_ptr, count, beat, rr_ptr = 0; storage data and ids = 0.
REQ-029 During and right after reset: rsp_valid_o=0, rsp_last_o=0, req_ready_o=0 while rst_ni low, rsp_data_o=0, rsp_id_o=0.
REQ-030 Reset mid-transfer SHALL discard all stored words and partial beat progress; no beat of a discarded word SHALL appear afterwards.

Configuration
REQ-031 Macro HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN defined: grant SHALL be fixed priority, lowest index wins, rr_ptr removed; undefined: round-robin per REQ-018/019.

Verification
REQ-032 Defaults, reset, then req_valid_i=2'b01 data0=256'h0004_..._0003_..._0002_..._0001 (beats 1..4) -> req_ready_o=01; next 4 cycles with rsp_ready_i=1 beats 1,2,3,4, id=0, rsp_last_o only on 4th.
REQ-033 Both requesters valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; rsp_id_o sequence per word 0,1,0,1.
REQ-034 rsp_ready_i=0, both valid -> exactly 2 pushes, then req_ready_o=00 held; raise rsp_ready_i -> 4 beats later last pop and no same-cycle push; push occurs next cycle.
REQ-035 count=1, beat=3, rsp_ready_i=1 and push same cycle -> count stays 1, rd_ptr advances, new word beat 0 presented next cycle.
REQ-036 Reset asserted after beat 2 of a word -> rsp_valid_o=0 immediately; after release, new word starts at beat 0 with rr_ptr=0.
REQ-037 With HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN, both valid, rsp_ready_i=1 -> requester 0 granted every push; requester 1 only when req_valid_i[0]=0.
